// File: rtl/spi_loader_pkg.sv
// Shared opcodes, FSM encoding and helpers for the SPI loader master and its SCK generator.
package spi_loader_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    // States in which chip select is low and SCK is allowed to toggle.
    function automatic logic is_shifting(input state_t s);
        return (s == ST_CMD) || (s == ST_ADDR) || (s == ST_DUMMY) || (s == ST_DATA);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider: toggles every CLK_DIV clk while running; o_rise/o_fall flag the edge taken this cycle.
// Held at count 0 with SCK low while i_run is low; i_sck_en masks the pin without stopping the count.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_sck_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);

    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_sck;
    logic          w_term;
    logic          w_phase_nxt;

    assign w_term      = i_run && (r_cnt == TERM);
    assign w_phase_nxt = w_term ? ~r_phase : r_phase;
    assign o_rise      = w_term && !r_phase;
    assign o_fall      = w_term && r_phase;
    assign o_sck       = r_sck;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_sck   <= 1'b0;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_sck   <= 1'b0;
        end else begin
            r_cnt   <= w_term ? '0 : r_cnt + 1'b1;
            r_phase <= w_phase_nxt;
            r_sck   <= i_sck_en && w_phase_nxt;
        end
    end

endmodule

// File: rtl/spi_loader_master.sv
// SPI mode-0 initiator: 8-bit opcode, 32-bit address, optional dummy cycles, 32-bit data; CS low the cycle after accept.
// Accepts one request at a time (ready only in IDLE, after the CS gap); rsp_valid pulses as CS rises.
module spi_loader_master
    import spi_loader_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_CYCLES = 32,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        busy_o,
    output logic        spi_clk_o,
    output logic        spi_cs_o,
    output logic        spi_sdo_o,
    input  logic        spi_sdi_i
);

    localparam logic [7:0] DUMMY_LEN = 8'(DUMMY_CYCLES);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_bit_cnt;
    logic [31:0] r_tx;
    logic [31:0] r_rx;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_we;
    logic        r_cs;
    logic        r_rsp_vld;
    logic [7:0]  w_seg_len;
    logic        w_hs;
    logic        w_seg_done;
    logic        w_gap_done;
    logic        w_run;
    logic        w_sck_en;
    logic        w_sck;
    logic        w_rise;
    logic        w_fall;

    assign w_run    = (r_state != ST_IDLE);
    assign w_sck_en = is_shifting(w_state_nxt);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_run    (w_run),
        .i_sck_en (w_sck_en),
        .o_sck    (w_sck),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    always_comb begin
        w_seg_len = 8'd32;
        case (r_state)
            ST_CMD:   w_seg_len = 8'd8;
            ST_DUMMY: w_seg_len = DUMMY_LEN;
            default:  w_seg_len = 8'd32;
        endcase
    end

    // A segment ends on the falling edge that follows its last rising edge.
    assign w_hs       = (r_state == ST_IDLE) && req_valid_i;
    assign w_seg_done = w_fall && (r_bit_cnt == w_seg_len);
    assign w_gap_done = w_fall && (r_bit_cnt == GAP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_hs)       w_state_nxt = ST_CMD;
            ST_CMD:   if (w_seg_done) w_state_nxt = ST_ADDR;
            ST_ADDR:  if (w_seg_done) w_state_nxt = (r_we || DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
            ST_DUMMY: if (w_seg_done) w_state_nxt = ST_DATA;
            ST_DATA:  if (w_seg_done) w_state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_gap_done) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_we      <= 1'b0;
            r_cs      <= 1'b1;
            r_rsp_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cs      <= !is_shifting(w_state_nxt);
            r_rsp_vld <= 1'b0;
            if (w_hs) begin
                r_we      <= req_we_i;
                r_addr    <= req_addr_i;
                r_wdata   <= req_wdata_i;
                r_tx      <= {(req_we_i ? CMD_WRITE : CMD_READ), 24'h0};
                r_bit_cnt <= '0;
            end else if (r_state == ST_GAP) begin
                // The divider keeps running here so the gap is measured in whole SCK periods.
                if (w_fall) begin
                    r_bit_cnt <= w_gap_done ? 8'd0 : r_bit_cnt + 8'd1;
                end
            end else if (w_rise) begin
                r_bit_cnt <= r_bit_cnt + 8'd1;
                if (r_state == ST_DATA && !r_we) begin
                    r_rx <= {r_rx[30:0], spi_sdi_i};
                end
            end else if (w_seg_done) begin
                r_bit_cnt <= '0;
                case (r_state)
                    ST_CMD:   r_tx <= r_addr;
                    ST_ADDR:  r_tx <= r_we ? r_wdata : 32'h0;
                    ST_DUMMY: r_tx <= '0;
                    default: begin
                        r_tx      <= '0;
                        r_rsp_vld <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= r_rx;
                        end
                    end
                endcase
            end else if (w_fall) begin
                r_tx <= {r_tx[30:0], 1'b0};
            end
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign busy_o      = (r_state != ST_IDLE);
    assign spi_cs_o    = r_cs;
    assign spi_clk_o   = w_sck;
    assign spi_sdo_o   = r_tx[31];
    assign rsp_valid_o = r_rsp_vld;
    assign rsp_rdata_o = r_rdata;

endmodule

// File: tb/tb_spi_loader_master.sv
// Directed bench: dut0 uses defaults, dut1/dut2 run CLK_DIV=1 and CLK_DIV=7; SPI pins are watched per instance.
module tb_spi_loader_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  sdi = 3'b000;
    wire  [2:0]  ready, busy, sck, cs, sdo, rvld;
    wire  [31:0] rdata0, rdata1, rdata2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int divs [3] = '{4, 1, 7};
    int rises [3];
    int pulses [3];
    int unstable [3];
    int rdy_viol [3];
    int pulse_viol [3];
    int lat [3];
    int last_rise [3];
    int cs_fall_c [3];
    int cs_rise_c [3] = '{-1, -1, -1};
    int pmin [3] = '{1000, 1000, 1000};
    int pmax [3];
    int min_gap = 1000;
    logic [127:0] mosi [3];
    logic [2:0]   p_sck = 3'b000;
    logic [2:0]   p_sdo = 3'b000;
    logic [2:0]   p_cs  = 3'b111;
    logic [31:0]  rd_word = 32'h12345678;

    always #5 clk = ~clk;

    spi_loader_master dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[0]), .req_ready_o(ready[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvld[0]), .rsp_rdata_o(rdata0), .busy_o(busy[0]),
        .spi_clk_o(sck[0]), .spi_cs_o(cs[0]), .spi_sdo_o(sdo[0]), .spi_sdi_i(sdi[0])
    );

    spi_loader_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[1]), .req_ready_o(ready[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvld[1]), .rsp_rdata_o(rdata1), .busy_o(busy[1]),
        .spi_clk_o(sck[1]), .spi_cs_o(cs[1]), .spi_sdo_o(sdo[1]), .spi_sdi_i(sdi[1])
    );

    spi_loader_master #(.CLK_DIV(7)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(valid[2]), .req_ready_o(ready[2]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rvld[2]), .rsp_rdata_o(rdata2), .busy_o(busy[2]),
        .spi_clk_o(sck[2]), .spi_cs_o(cs[2]), .spi_sdo_o(sdo[2]), .spi_sdi_i(sdi[2])
    );

    // Pin monitor: edge counts, captured MOSI, SCK timing and protocol sanity per instance.
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (p_cs[i] && !cs[i]) begin
                rises[i]     = 0;
                mosi[i]      = '0;
                cs_fall_c[i] = cyc;
                lat[i]       = -1;
                if (i == 0 && cs_rise_c[0] >= 0 && (cyc - cs_rise_c[0]) < min_gap)
                    min_gap = cyc - cs_rise_c[0];
            end
            if (!p_cs[i] && cs[i]) begin
                cs_rise_c[i] = cyc;
                if (sck[i]) pulse_viol[i]++;
            end
            if (!p_sck[i] && sck[i]) begin
                if (sdo[i] !== p_sdo[i]) unstable[i]++;
                if (rises[i] == 0) begin
                    lat[i] = cyc - cs_fall_c[i];
                end else begin
                    if (cyc - last_rise[i] < pmin[i]) pmin[i] = cyc - last_rise[i];
                    if (cyc - last_rise[i] > pmax[i]) pmax[i] = cyc - last_rise[i];
                end
                last_rise[i] = cyc;
                rises[i]++;
                mosi[i] = {mosi[i][126:0], sdo[i]};
            end
            if (rvld[i]) begin
                pulses[i]++;
                if (!(cs[i] && !p_cs[i])) pulse_viol[i]++;
            end
            if (!cs[i] && ready[i]) rdy_viol[i]++;
        end
        p_sck = sck;
        p_sdo = sdo;
        p_cs  = cs;
    end

    // Slave model for dut0: read data shifted out on SCK falling edges after 72 rising edges.
    always @(negedge sck[0]) begin
        if (!cs[0] && rises[0] >= 72 && rises[0] < 104)
            sdi[0] = rd_word[103 - rises[0]];
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [2:0] m, input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        valid     = valid | m;
        while ((ready & m) != m && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("hs_ready", {125'b0, ready & m}, {125'b0, m});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input logic [2:0] m);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy & m) != 3'b000 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", {125'b0, busy & m}, 128'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; valid = 3'b000; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_cs",    cs,    3'b111);
        check("rst_sck",   sck,   3'b000);
        check("rst_sdo",   sdo,   3'b000);
        check("rst_busy",  busy,  3'b000);
        check("rst_rvld",  rvld,  3'b000);
        check("rst_rdata", rdata0, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 3'b111);

        send(3'b001, 1'b1, 32'h00080000, 32'hDEADBEEF);
        valid = 3'b000;
        wait_idle(3'b001);
        check("wr_rises",  rises[0], 72);
        check("wr_mosi",   mosi[0][71:0], {8'h02, 32'h00080000, 32'hDEADBEEF});
        check("wr_pulses", pulses[0], 1);
        check("wr_rdata",  rdata0, 32'h0);
        check("wr_lat",    lat[0], 4);
        check("wr_period", {pmin[0], pmax[0]}, {32'd8, 32'd8});

        send(3'b001, 1'b0, 32'h00100004, 32'h0);
        valid = 3'b000;
        wait_idle(3'b001);
        check("rd_rises",  rises[0], 104);
        check("rd_mosi",   mosi[0][103:0], {8'h0B, 32'h00100004, 64'h0});
        check("rd_rdata",  rdata0, 32'h12345678);
        check("rd_pulses", pulses[0], 2);

        min_gap = 1000;
        send(3'b001, 1'b1, 32'h00000100, 32'hA5A5A5A5);
        send(3'b001, 1'b1, 32'h00000104, 32'h5A5A5A5A);
        valid = 3'b000;
        wait_idle(3'b001);
        check("b2b_gap_ge16", {127'b0, min_gap >= 16}, 128'd1);
        check("b2b_ready",    rdy_viol[0], 0);
        check("b2b_mosi",     mosi[0][71:0], {8'h02, 32'h00000104, 32'h5A5A5A5A});
        check("b2b_pulses",   pulses[0], 4);
        check("b2b_rdata",    rdata0, 32'h12345678);

        send(3'b001, 1'b1, 32'h00000200, 32'h11112222);
        valid = 3'b000;
        for (int n = 0; n < 5000 && rises[0] < 18; n++) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_cs",   cs[0], 1'b1);
        check("abort_sck",  sck[0], 1'b0);
        check("abort_busy", busy[0], 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_nopulse", pulses[0], 4);
        check("abort_rdata",   rdata0, 32'h0);
        send(3'b001, 1'b1, 32'h00000300, 32'hCAFEF00D);
        valid = 3'b000;
        wait_idle(3'b001);
        check("post_rises",  rises[0], 72);
        check("post_mosi",   mosi[0][71:0], {8'h02, 32'h00000300, 32'hCAFEF00D});
        check("post_pulses", pulses[0], 5);

        send(3'b110, 1'b1, 32'h00000400, 32'h0F0F00FF);
        valid = 3'b000;
        wait_idle(3'b110);
        for (int i = 1; i < 3; i++) begin
            check("div_rises",  rises[i], 72);
            check("div_mosi",   mosi[i][71:0], {8'h02, 32'h00000400, 32'h0F0F00FF});
            check("div_period", {pmin[i], pmax[i]}, {32'(2 * divs[i]), 32'(2 * divs[i])});
            check("div_lat",    lat[i], divs[i]);
            check("div_pulses", pulses[i], 1);
        end
        for (int i = 0; i < 3; i++) begin
            check("mosi_stable", unstable[i], 0);
            check("cs_rise_rules", pulse_viol[i], 0);
            check("ready_in_txn", rdy_viol[i], 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
